bias_relu_seq: RTL and testbench

- Sequential bias-add + ReLU stage directly downstream of the multi-channel max-pool stage in the LeNet-style CNN datapath.
- Consumes the flat pooled feature map (D channels of H x W, signed fixed point) and produces the activated map for the next convolution layer.
- Processes one element per clock under a start/busy/done handshake, so one adder/saturator is shared across the whole map.

---
 rtl/cnn_pkg.sv | 28 ++
 rtl/bias_relu_lane.sv | 41 ++++
 rtl/bias_relu_seq.sv | 103 ++++++++++
 tb/tb_bias_relu_seq.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN datapath stages: default element width,
// signed saturation limits and the sequencer state encoding.
package cnn_pkg;

  localparam int DEF_DATA_WIDTH = 16;

  function automatic int sat_max(input int dw);
    return (1 << (dw - 1)) - 1;
  endfunction

  function automatic int sat_min(input int dw);
    return -(1 << (dw - 1));
  endfunction

  localparam int SAT_MAX = sat_max(DEF_DATA_WIDTH);
  localparam int SAT_MIN = sat_min(DEF_DATA_WIDTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/bias_relu_lane.sv
// Single-element bias add, signed saturation and activation.
// Build option BIAS_RELU_LEAKY_EN: negative results pass as sat >>> 3
// (leaky slope 1/8) instead of being clamped to zero.
module bias_relu_lane
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [DATA_WIDTH-1:0] bias_c,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam logic signed [DATA_WIDTH:0] SUM_HI = (DATA_WIDTH+1)'(sat_max(DATA_WIDTH));
  localparam logic signed [DATA_WIDTH:0] SUM_LO = (DATA_WIDTH+1)'(sat_min(DATA_WIDTH));

  logic signed [DATA_WIDTH:0]   sum;
  logic signed [DATA_WIDTH-1:0] sat;

  // One extra bit of headroom makes the add exact; clamp, then activate.
  always_comb begin
    sum = $signed({din[DATA_WIDTH-1], din}) + $signed({bias_c[DATA_WIDTH-1], bias_c});
    if (sum > SUM_HI)
      sat = SUM_HI[DATA_WIDTH-1:0];
    else if (sum < SUM_LO)
      sat = SUM_LO[DATA_WIDTH-1:0];
    else
      sat = sum[DATA_WIDTH-1:0];

    if (sat[DATA_WIDTH-1]) begin
`ifdef BIAS_RELU_LEAKY_EN
      dout = sat >>> 3;
`else
      dout = '0;
`endif
    end else begin
      dout = sat;
    end
  end

endmodule

// File: rtl/bias_relu_seq.sv
// Sequential bias + activation over a D x H x W pooled map, one element per
// clock through a single shared lane. Activation flavour is selected in
// bias_relu_lane by BIAS_RELU_LEAKY_EN.
//
// state | meaning
// IDLE  | waiting for start; counters parked
// RUN   | writing element e = c*H*W + p each edge
// DONE  | one-cycle done pulse, then back to IDLE
module bias_relu_seq
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int D          = 6,
  parameter int H          = 14,
  parameter int W          = 14
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [H*W*D*DATA_WIDTH-1:0]  apInput,
  input  logic [D*DATA_WIDTH-1:0]      bias,
  output logic [H*W*D*DATA_WIDTH-1:0]  apOutput,
  output logic                         busy,
  output logic                         done
);

  localparam int HW = H * W;
  localparam int N  = HW * D;
  localparam int PW = (HW > 1) ? $clog2(HW) : 1;
  localparam int CW = (D > 1) ? $clog2(D) : 1;
  localparam int EW = (N > 1) ? $clog2(N) : 1;

  state_t          state, state_nx;
  logic [PW-1:0]   p;
  logic [CW-1:0]   c;
  logic [EW-1:0]   e;
  logic            p_wrap;
  logic            last_elem;
  logic [DATA_WIDTH-1:0] lane_out;

  assign p_wrap    = (p == PW'(HW - 1));
  assign last_elem = (e == EW'(N - 1));

  bias_relu_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
    .din    (apInput[e*DATA_WIDTH +: DATA_WIDTH]),
    .bias_c (bias[c*DATA_WIDTH +: DATA_WIDTH]),
    .dout   (lane_out)
  );

  // Next-state decode; start only matters in IDLE.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last_elem) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register with busy/done registered from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx == RUN);
      done  <= (state_nx == DONE);
    end
  end

  // Nested pixel/channel counters plus a flat element index for the map.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p <= '0;
      c <= '0;
      e <= '0;
    end else if (state == IDLE && start) begin
      p <= '0;
      c <= '0;
      e <= '0;
    end else if (state == RUN) begin
      e <= e + 1'b1;
      if (p_wrap) begin
        p <= '0;
        c <= c + 1'b1;
      end else begin
        p <= p + 1'b1;
      end
    end
  end

  // Output map: only the current element is rewritten, the rest hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      apOutput <= '0;
    else if (state == RUN)
      apOutput[e*DATA_WIDTH +: DATA_WIDTH] <= lane_out;
  end

endmodule

// File: tb/tb_bias_relu_seq.sv
// Testbench for bias_relu_seq: directed and random maps checked against a
// plain-arithmetic reference of bias add, clamp and activation.
module tb_bias_relu_seq;
  import cnn_pkg::*;

  localparam int DW = 16;
  localparam int D  = 6;
  localparam int H  = 14;
  localparam int W  = 14;
  localparam int HW = H * W;
  localparam int N  = HW * D;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic [N*DW-1:0] apInput;
  logic [D*DW-1:0] bias;
  logic [N*DW-1:0] apOutput;
  logic busy, done;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] in_mem   [N];
  logic [DW-1:0] bias_mem [D];
  logic [DW-1:0] exp_mem  [N];
  logic [DW-1:0] prev_mem [N];

  int busy_cnt, done_cnt, done_k, first_busy_k;
  logic [DW-1:0] snap_old, snap_new;
  logic snap_zero, snap_busy, snap_done;

  always #5 clk = ~clk;

  bias_relu_seq #(.DATA_WIDTH(DW), .D(D), .H(H), .W(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .apInput  (apInput),
    .bias     (bias),
    .apOutput (apOutput),
    .busy     (busy),
    .done     (done)
  );

  function automatic logic [DW-1:0] ref_elem(input logic [DW-1:0] x, input logic [DW-1:0] b);
    int s;
    s = int'($signed(x)) + int'($signed(b));
    if (s > SAT_MAX) s = SAT_MAX;
    if (s < SAT_MIN) s = SAT_MIN;
    if (s < 0) begin
`ifdef BIAS_RELU_LEAKY_EN
      s = -((-s + 7) / 8);
`else
      s = 0;
`endif
    end
    return s[DW-1:0];
  endfunction

  // Pack the stimulus arrays onto the DUT and rebuild the expected map.
  task automatic load_inputs();
    for (int i = 0; i < N; i++) prev_mem[i] = exp_mem[i];
    for (int i = 0; i < N; i++) apInput[i*DW +: DW] = in_mem[i];
    for (int ch = 0; ch < D; ch++) bias[ch*DW +: DW] = bias_mem[ch];
    for (int i = 0; i < N; i++) exp_mem[i] = ref_elem(in_mem[i], bias_mem[i / HW]);
  endtask

  function automatic int first_mismatch();
    for (int i = 0; i < N; i++)
      if (apOutput[i*DW +: DW] !== exp_mem[i]) return i;
    return -1;
  endfunction

  // Pulse start and watch a bounded window; k counts negedges after edge 0.
  task automatic drive_run(input int inj_k, input int rst_k);
    busy_cnt = 0; done_cnt = 0; done_k = -1; first_busy_k = -1;
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k < N + 5; k++) begin
      @(negedge clk);
      if (busy === 1'b1) begin
        busy_cnt++;
        if (first_busy_k < 0) first_busy_k = k;
      end
      if (done === 1'b1) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end
      if (k == 0) start = 1'b0;
      if (k == inj_k) start = 1'b1;
      if (k == inj_k + 1) start = 1'b0;
      if (k == rst_k) begin
        snap_old = apOutput[rst_k*DW +: DW];
        snap_new = apOutput[(rst_k-1)*DW +: DW];
        reset = 1'b1;
        #1;
        snap_zero = (apOutput == '0);
        snap_busy = busy;
        snap_done = done;
      end
      if (k == rst_k + 1) reset = 1'b0;
    end
  endtask

  task automatic test_reset();
    int idx;
    reset = 1'b1; start = 1'b0;
    for (int i = 0; i < N; i++) begin in_mem[i] = 16'h1234; exp_mem[i] = '0; end
    for (int ch = 0; ch < D; ch++) bias_mem[ch] = 16'h0001;
    for (int i = 0; i < N; i++) apInput[i*DW +: DW] = in_mem[i];
    for (int ch = 0; ch < D; ch++) bias[ch*DW +: DW] = bias_mem[ch];
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy actual=%b required=0", busy); end
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL reset_done actual=%b required=0", done); end
    idx = first_mismatch();
    checks++;
    if (idx != -1) begin failures++; $display("FAIL reset_map elem=%0d actual=%h required=0000", idx, apOutput[idx*DW +: DW]); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL idle_no_start busy actual=%b required=0", busy); end
  endtask

  task automatic test_basic();
    int idx;
    for (int i = 0; i < N; i++) in_mem[i] = 16'h0010;
    for (int ch = 0; ch < D; ch++) bias_mem[ch] = 16'h0005;
    load_inputs();
    drive_run(-1, -1);
    checks++;
    if (busy_cnt != N) begin failures++; $display("FAIL basic_busy_cycles actual=%0d required=%0d", busy_cnt, N); end
    checks++;
    if (first_busy_k != 0) begin failures++; $display("FAIL basic_busy_start actual=%0d required=0", first_busy_k); end
    checks++;
    if (done_cnt != 1 || done_k != N) begin failures++; $display("FAIL basic_done count=%0d at=%0d required count=1 at=%0d", done_cnt, done_k, N); end
    idx = first_mismatch();
    checks++;
    if (idx != -1) begin failures++; $display("FAIL basic_map elem=%0d actual=%h required=%h", idx, apOutput[idx*DW +: DW], exp_mem[idx]); end
    checks++;
    if (apOutput[0 +: DW] !== 16'h0015) begin failures++; $display("FAIL basic_value actual=%h required=0015", apOutput[0 +: DW]); end
  endtask

  task automatic test_saturation();
    int idx;
    for (int i = 0; i < N; i++) in_mem[i] = (i / HW < 3) ? 16'h7FF0 : 16'h8005;
    for (int ch = 0; ch < D; ch++) bias_mem[ch] = (ch < 3) ? 16'h0020 : 16'hFFF0;
    load_inputs();
    drive_run(-1, -1);
    idx = first_mismatch();
    checks++;
    if (idx != -1) begin failures++; $display("FAIL saturation_map elem=%0d actual=%h required=%h", idx, apOutput[idx*DW +: DW], exp_mem[idx]); end
    checks++;
    if (apOutput[0 +: DW] !== 16'h7FFF) begin failures++; $display("FAIL pos_sat actual=%h required=7fff", apOutput[0 +: DW]); end
    checks++;
`ifdef BIAS_RELU_LEAKY_EN
    if (apOutput[(N-1)*DW +: DW] !== 16'hF000) begin failures++; $display("FAIL neg_sat actual=%h required=f000", apOutput[(N-1)*DW +: DW]); end
`else
    if (apOutput[(N-1)*DW +: DW] !== 16'h0000) begin failures++; $display("FAIL neg_sat actual=%h required=0000", apOutput[(N-1)*DW +: DW]); end
`endif
  endtask

  task automatic test_channel_bias();
    int idx;
    for (int i = 0; i < N; i++) in_mem[i] = 16'h0000;
    for (int ch = 0; ch < D; ch++) bias_mem[ch] = 16'(ch * 16'h0100);
    load_inputs();
    drive_run(-1, -1);
    idx = first_mismatch();
    checks++;
    if (idx != -1) begin failures++; $display("FAIL channel_map elem=%0d actual=%h required=%h", idx, apOutput[idx*DW +: DW], exp_mem[idx]); end
    for (int ch = 1; ch < D; ch++) begin
      checks++;
      if (apOutput[(ch*HW-1)*DW +: DW] !== 16'((ch-1) * 16'h0100) ||
          apOutput[(ch*HW)*DW +: DW]   !== 16'(ch * 16'h0100)) begin
        failures++;
        $display("FAIL channel_wrap ch=%0d actual=%h/%h required=%h/%h", ch,
                 apOutput[(ch*HW-1)*DW +: DW], apOutput[(ch*HW)*DW +: DW],
                 16'((ch-1) * 16'h0100), 16'(ch * 16'h0100));
      end
    end
  endtask

  task automatic test_small_negative();
    int idx;
    for (int i = 0; i < N; i++) in_mem[i] = 16'hFFF8;
    for (int ch = 0; ch < D; ch++) bias_mem[ch] = 16'h0000;
    load_inputs();
    drive_run(-1, -1);
    idx = first_mismatch();
    checks++;
    if (idx != -1) begin failures++; $display("FAIL small_neg_map elem=%0d actual=%h required=%h", idx, apOutput[idx*DW +: DW], exp_mem[idx]); end
  endtask

  task automatic test_random();
    int idx;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < N; i++) in_mem[i] = 16'($urandom);
      for (int ch = 0; ch < D; ch++) bias_mem[ch] = 16'($urandom);
      load_inputs();
      drive_run(-1, -1);
      idx = first_mismatch();
      checks++;
      if (idx != -1) begin failures++; $display("FAIL random_map run=%0d elem=%0d actual=%h required=%h", r, idx, apOutput[idx*DW +: DW], exp_mem[idx]); end
      checks++;
      if (done_k != N) begin failures++; $display("FAIL random_done run=%0d at=%0d required=%0d", r, done_k, N); end
    end
  endtask

  task automatic test_start_ignored();
    int idx;
    for (int i = 0; i < N; i++) in_mem[i] = 16'($urandom_range(0, 16'h3FFF));
    for (int ch = 0; ch < D; ch++) bias_mem[ch] = 16'($urandom_range(0, 16'h00FF));
    load_inputs();
    drive_run(100, -1);
    checks++;
    if (busy_cnt != N) begin failures++; $display("FAIL restart_busy actual=%0d required=%0d", busy_cnt, N); end
    checks++;
    if (done_cnt != 1 || done_k != N) begin failures++; $display("FAIL restart_done count=%0d at=%0d required count=1 at=%0d", done_cnt, done_k, N); end
    idx = first_mismatch();
    checks++;
    if (idx != -1) begin failures++; $display("FAIL restart_map elem=%0d actual=%h required=%h", idx, apOutput[idx*DW +: DW], exp_mem[idx]); end
  endtask

  task automatic test_reset_midrun();
    int idx;
    for (int i = 0; i < N; i++) in_mem[i] = 16'($urandom);
    for (int ch = 0; ch < D; ch++) bias_mem[ch] = 16'($urandom);
    load_inputs();
    drive_run(-1, 500);
    checks++;
    if (snap_new !== exp_mem[499]) begin failures++; $display("FAIL midrun_written actual=%h required=%h", snap_new, exp_mem[499]); end
    checks++;
    if (snap_old !== prev_mem[500]) begin failures++; $display("FAIL midrun_hold actual=%h required=%h", snap_old, prev_mem[500]); end
    checks++;
    if (snap_zero !== 1'b1 || snap_busy !== 1'b0 || snap_done !== 1'b0) begin
      failures++;
      $display("FAIL midrun_reset zero=%b busy=%b done=%b required 1/0/0", snap_zero, snap_busy, snap_done);
    end
    checks++;
    if (done_cnt != 0 || busy_cnt != 501) begin failures++; $display("FAIL midrun_abort done=%0d busy=%0d required done=0 busy=501", done_cnt, busy_cnt); end
    for (int i = 0; i < N; i++) exp_mem[i] = '0;
    for (int i = 0; i < N; i++) in_mem[i] = 16'($urandom);
    load_inputs();
    drive_run(-1, -1);
    checks++;
    if (busy_cnt != N || done_cnt != 1 || done_k != N) begin
      failures++;
      $display("FAIL after_reset_timing busy=%0d done=%0d at=%0d required %0d/1/%0d", busy_cnt, done_cnt, done_k, N, N);
    end
    idx = first_mismatch();
    checks++;
    if (idx != -1) begin failures++; $display("FAIL after_reset_map elem=%0d actual=%h required=%h", idx, apOutput[idx*DW +: DW], exp_mem[idx]); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_channel_bias();
    test_small_negative();
    test_random();
    test_start_ignored();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
